// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single fixed-latency memory.
// One access runs at a time: grant, LATENCY-1 wait edges, one ACCESS cycle, one DONE cycle.
module mem_arbiter #(
  parameter int LATENCY = 20
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  output logic [31:0] I_rdata,
  output logic        I_ready,
  input  logic        D_req,
  input  logic        D_we,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_wdata,
  output logic [31:0] D_rdata,
  output logic        D_ready,
  output logic        Mem_en,
  output logic        Mem_we,
  output logic [29:0] Mem_addr,
  output logic [31:0] Mem_wdata,
  input  logic [31:0] Mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(LATENCY - 1);

  state_t     state;
  logic [7:0] count;
  logic       own_d;
  logic       we_l;
  logic       last_d;
  logic       take_d;
  logic       unused_lsbs;

  // Data side wins unless the instruction side also pends and data had the last grant.
  function automatic logic pick_d(input logic i_pend, input logic d_pend, input logic prev_d);
    return d_pend && !(i_pend && prev_d);
  endfunction

  assign take_d      = pick_d(I_req, D_req, last_d);
  assign unused_lsbs = ^{I_addr[1:0], D_addr[1:0]};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      own_d     <= 1'b0;
      we_l      <= 1'b0;
      last_d    <= 1'b0;
      I_ready   <= 1'b0;
      D_ready   <= 1'b0;
      I_rdata   <= 32'd0;
      D_rdata   <= 32'd0;
      Mem_en    <= 1'b0;
      Mem_we    <= 1'b0;
      Mem_addr  <= 30'd0;
      Mem_wdata <= 32'd0;
    end else begin
      I_ready <= 1'b0;
      D_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (I_req || D_req) begin
            own_d     <= take_d;
            last_d    <= take_d;
            we_l      <= take_d && D_we;
            Mem_addr  <= take_d ? D_addr[31:2] : I_addr[31:2];
            Mem_wdata <= D_wdata;
            count     <= 8'd1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          count <= count + 8'd1;
          if (count == LAST_WAIT) begin
            Mem_en <= 1'b1;
            Mem_we <= we_l;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          Mem_en <= 1'b0;
          Mem_we <= 1'b0;
          if (!we_l) begin
            if (own_d) D_rdata <= Mem_rdata;
            else       I_rdata <= Mem_rdata;
          end
          if (own_d) D_ready <= 1'b1;
          else       I_ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one LATENCY=20 and one LATENCY=2 instance, each with its own
// memory, checked every cycle against a transaction-timeline reference model.
module tb_mem_arbiter;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic        i_req[2], d_req[2], d_we[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2];
  logic [31:0] i_rdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
  logic        i_ready[2], d_ready[2], mem_en[2], mem_we[2];
  logic [29:0] mem_addr[2];
  logic [31:0] mem[2][256];

  logic        bd_init, bd_wr;
  int          bd_g;
  logic [7:0]  bd_a;
  logic [31:0] bd_d;

  int n_chk = 0;
  int n_err = 0;

  function automatic int lat(input int g);
    return (g == 0) ? 20 : 2;
  endfunction

  function automatic logic [31:0] pat(input int g, input int i);
    return (32'(i) * 32'h0100_0193) ^ (32'(g + 1) << 28);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      mem_arbiter #(.LATENCY(gi == 0 ? 20 : 2)) u_dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .I_req    (i_req[gi]),
        .I_addr   (i_addr[gi]),
        .I_rdata  (i_rdata[gi]),
        .I_ready  (i_ready[gi]),
        .D_req    (d_req[gi]),
        .D_we     (d_we[gi]),
        .D_addr   (d_addr[gi]),
        .D_wdata  (d_wdata[gi]),
        .D_rdata  (d_rdata[gi]),
        .D_ready  (d_ready[gi]),
        .Mem_en   (mem_en[gi]),
        .Mem_we   (mem_we[gi]),
        .Mem_addr (mem_addr[gi]),
        .Mem_wdata(mem_wdata[gi]),
        .Mem_rdata(mem_rdata[gi])
      );
      assign mem_rdata[gi] = mem[gi][mem_addr[gi][7:0]];
    end
  endgenerate

  // Memory behind each DUT, with a backdoor for preloading.
  always @(posedge Clk) begin
    if (bd_init) begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < 256; i++) mem[g][i] <= pat(g, i);
    end else if (bd_wr) begin
      mem[bd_g][bd_a] <= bd_d;
    end else begin
      for (int g = 0; g < 2; g++)
        if (mem_en[g] && mem_we[g]) mem[g][mem_addr[g][7:0]] <= mem_wdata[g];
    end
  end

  // Reference model: each access is a transaction granted at edge tg, strobing memory in
  // the cycle after edge tg+L-1, completing after edge tg+L, arbiter free again at tg+L+2.
  int          m_cyc;
  bit          m_busy[2], m_own[2], m_we[2], m_last[2];
  int          m_tg[2];
  logic [29:0] m_addr[2];
  logic [31:0] m_wd[2], e_ird[2], e_drd[2];
  logic [31:0] rmem[2][256];

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_cyc <= 0;
      for (int g = 0; g < 2; g++) begin
        m_busy[g] <= 1'b0;
        m_last[g] <= 1'b0;
        e_ird[g]  <= 32'd0;
        e_drd[g]  <= 32'd0;
        m_addr[g] <= 30'd0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      if (bd_init) begin
        for (int g = 0; g < 2; g++)
          for (int i = 0; i < 256; i++) rmem[g][i] <= pat(g, i);
      end else if (bd_wr) begin
        rmem[bd_g][bd_a] <= bd_d;
      end
      for (int g = 0; g < 2; g++) begin
        if (m_busy[g] && (m_cyc + 1 == m_tg[g] + lat(g))) begin
          if (m_we[g])       rmem[g][m_addr[g][7:0]] <= m_wd[g];
          else if (m_own[g]) e_drd[g] <= rmem[g][m_addr[g][7:0]];
          else               e_ird[g] <= rmem[g][m_addr[g][7:0]];
        end
        if (m_busy[g]) begin
          if (m_cyc + 1 == m_tg[g] + lat(g) + 1) m_busy[g] <= 1'b0;
        end else if (i_req[g] || d_req[g]) begin
          m_busy[g] <= 1'b1;
          m_tg[g]   <= m_cyc + 1;
          m_own[g]  <= d_req[g] && !(i_req[g] && m_last[g]);
          m_last[g] <= d_req[g] && !(i_req[g] && m_last[g]);
          m_we[g]   <= d_req[g] && !(i_req[g] && m_last[g]) && d_we[g];
          m_addr[g] <= (d_req[g] && !(i_req[g] && m_last[g])) ? d_addr[g][31:2] : i_addr[g][31:2];
          m_wd[g]   <= d_wdata[g];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every DUT output with the model.
  task automatic tick();
    @(negedge Clk);
    for (int g = 0; g < 2; g++) begin
      bit en_x, ack;
      en_x = m_busy[g] && (m_cyc == m_tg[g] + lat(g) - 1);
      ack  = m_busy[g] && (m_cyc == m_tg[g] + lat(g));
      chk($sformatf("g%0d mem_en", g),  32'(mem_en[g]),  32'(en_x));
      chk($sformatf("g%0d mem_we", g),  32'(mem_we[g]),  32'(en_x && m_we[g]));
      chk($sformatf("g%0d i_ready", g), 32'(i_ready[g]), 32'(ack && !m_own[g]));
      chk($sformatf("g%0d d_ready", g), 32'(d_ready[g]), 32'(ack && m_own[g]));
      chk($sformatf("g%0d i_rdata", g), i_rdata[g], e_ird[g]);
      chk($sformatf("g%0d d_rdata", g), d_rdata[g], e_drd[g]);
      if (m_busy[g]) chk($sformatf("g%0d mem_addr", g), 32'(mem_addr[g]), 32'(m_addr[g]));
      if (en_x && m_we[g]) chk($sformatf("g%0d mem_wdata", g), mem_wdata[g], m_wd[g]);
    end
  endtask

  task automatic d_txn(input int g, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input bit swap, output int n);
    bit seen;
    d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = a; d_wdata[g] = wd;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      tick();
      n++;
      if (swap && n == 3) d_addr[g] = 32'h80;
      seen = d_ready[g];
    end
    chk($sformatf("g%0d d_txn_done", g), 32'(seen), 32'd1);
    d_req[g] = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] old;
    int          order[$];

    Rst = 1'b0; bd_init = 1'b0; bd_wr = 1'b0; bd_g = 0; bd_a = 8'd0; bd_d = 32'd0;
    for (int g = 0; g < 2; g++) begin
      i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      i_addr[g] = 32'd0; d_addr[g] = 32'd0; d_wdata[g] = 32'd0;
    end
    repeat (3) tick();
    chk("rst mem_addr",  32'(mem_addr[0]), 32'd0);
    chk("rst mem_wdata", mem_wdata[0], 32'd0);
    Rst = 1'b1;

    bd_init = 1'b1; tick(); bd_init = 1'b0;
    bd_wr = 1'b1; bd_g = 0; bd_a = 8'h10; bd_d = 32'hCAFE_F00D; tick(); bd_wr = 1'b0;
    repeat (2) tick();

    // Data read at 0x40, then write 0x44 and read it back.
    d_txn(0, 1'b0, 32'h40, 32'd0, 1'b0, n);
    chk("d_read_latency", 32'(n), 32'd21);
    chk("d_read_data", d_rdata[0], 32'hCAFE_F00D);
    repeat (2) tick();
    d_txn(0, 1'b1, 32'h44, 32'h1234_5678, 1'b0, n);
    tick();
    chk("d_write_mem", mem[0][8'h11], 32'h1234_5678);
    chk("d_write_keeps_rdata", d_rdata[0], 32'hCAFE_F00D);
    d_txn(0, 1'b0, 32'h44, 32'd0, 1'b0, n);
    chk("d_readback", d_rdata[0], 32'h1234_5678);
    tick();

    // Address change after grant must not affect the access.
    d_txn(0, 1'b0, 32'h40, 32'd0, 1'b1, n);
    chk("addr_change_ignored", d_rdata[0], 32'hCAFE_F00D);
    tick();

    // Both sides requesting straight out of reset: D first, then alternate.
    Rst = 1'b0;
    i_req[0] = 1'b1; i_addr[0] = 32'h48;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
    tick();
    Rst = 1'b1;
    n = 0;
    while (order.size() < 4 && n < 400) begin
      tick();
      n++;
      if (d_ready[0]) order.push_back(1);
      if (i_ready[0]) order.push_back(0);
    end
    chk("contend_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < order.size()) chk($sformatf("contend_order%0d", k), 32'(order[k]), 32'((k % 2) == 0));
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (30) tick();

    // Reset at count 10 of a write aborts it cleanly.
    old = mem[0][8'h12];
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h48; d_wdata[0] = 32'hDEAD_BEEF;
    repeat (10) tick();
    Rst = 1'b0; d_req[0] = 1'b0;
    tick();
    chk("abort mem_addr",  32'(mem_addr[0]), 32'd0);
    chk("abort mem_wdata", mem_wdata[0], 32'd0);
    chk("abort d_rdata",   d_rdata[0], 32'd0);
    Rst = 1'b1;
    repeat (30) tick();
    chk("abort mem_unchanged", mem[0][8'h12], old);

    // Minimum latency instance: ready two edges after grant.
    d_txn(1, 1'b0, 32'h10, 32'd0, 1'b0, n);
    chk("lat2_latency", 32'(n), 32'd3);
    tick();

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (i_req[g] && i_ready[g]) i_req[g] = 1'b0;
        else if (!i_req[g]) begin
          if ($urandom_range(0, 2) == 0) begin i_req[g] = 1'b1; i_addr[g] = $urandom; end
        end else if ($urandom_range(0, 9) == 0) i_addr[g] = $urandom;
        if (d_req[g] && d_ready[g]) d_req[g] = 1'b0;
        else if (!d_req[g]) begin
          if ($urandom_range(0, 2) == 0) begin
            d_req[g] = 1'b1; d_we[g] = $urandom_range(0, 1) == 1;
            d_addr[g] = $urandom; d_wdata[g] = $urandom;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          d_addr[g] = $urandom; d_wdata[g] = $urandom; d_we[g] = $urandom_range(0, 1) == 1;
        end
      end
    end
    for (int g = 0; g < 2; g++) begin i_req[g] = 1'b0; d_req[g] = 1'b0; end
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
